// File: rtl/fixed2float_pkg.sv
// Shared float-format constants, pipeline payload types and sizing helpers for fixed2float_pipe.
package fixed2float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int BIAS      = 2 ** (DEF_EXP_W - 1) - 1;
    localparam int FLOAT_W   = 1 + DEF_EXP_W + DEF_MAN_W;

    // Magnitudes travel MSB-aligned in a fixed 64-bit field whatever FIX_W is.
    localparam int MAG_W  = 64;
    localparam int EXP_FW = 16;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
    } float_t;

    typedef struct packed {
        logic                     valid;
        logic                     sign;
        logic                     zero;
        logic signed [EXP_FW-1:0] exp;  // leading-zero count after S2, unbiased exponent after S3
        logic [MAG_W-1:0]         mag;
    } stage_t;

    function automatic int lzc_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int bias_of(input int exp_w);
        return 2 ** (exp_w - 1) - 1;
    endfunction

endpackage

// File: rtl/fixed2float_lzc.sv
// Combinational leading-zero counter; count == WIDTH and zero == 1 for an all-zero input.
module fixed2float_lzc
    import fixed2float_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]        value,
    output logic [lzc_w(WIDTH)-1:0] count,
    output logic                    zero
);

    localparam int CNT_W = lzc_w(WIDTH);

    // Later iterations win, so the highest set bit decides the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
        zero = ~|value;
    end

endmodule

// File: rtl/fixed2float_pipe.sv
// Four-stage signed fixed-point to IEEE float converter, round-to-nearest-even, valid/ready.
// Defining FIXED2FLOAT_FLAGS_EN adds the m_inexact output.
module fixed2float_pipe
    import fixed2float_pkg::*;
#(
    parameter int FIX_W  = 32,
    parameter int FRAC_W = 16,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [FIX_W-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [EXP_W+MAN_W:0]   m_data
`ifdef FIXED2FLOAT_FLAGS_EN
    ,
    output logic                   m_inexact
`endif
);

    localparam int LZ_W   = lzc_w(MAG_W);
    localparam int E_OFF  = FIX_W - 1 - FRAC_W;
    localparam int BIAS_F = bias_of(EXP_W);
    localparam int MS_W   = MAN_W + 1;
    localparam int G_POS  = MAG_W - 2 - MAN_W;

    if (FIX_W < 2 || FIX_W > MAG_W || FRAC_W < 0 || FRAC_W > FIX_W ||
        EXP_W < 2 || EXP_W > EXP_FW - 1 || MAN_W < 1 || MAN_W > MAG_W - 3 ||
        FIX_W - FRAC_W >= BIAS_F || FRAC_W > BIAS_F - 1) begin : g_bad_params
        $fatal(1, "fixed2float_pipe: parameters leave the normal float range");
    end

    logic            stall;
    stage_t          s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic [FIX_W-1:0] abs_val;
    logic [LZ_W-1:0] lz;
    logic            lz_zero;
    logic            lsb, guard, sticky, round_up, is_zero;
    logic [MAN_W:0]  man_sum;
    logic [EXP_W-1:0] exp_out;

    assign stall   = m_valid && !m_ready;
    assign s_ready = !stall;

    // S1: sign/magnitude; the most negative input maps to 2^(FIX_W-1) without overflow.
    always_comb begin
        abs_val    = s_data[FIX_W-1] ? (~s_data + FIX_W'(1)) : s_data;
        s1_d       = '0;
        s1_d.valid = s_valid;
        s1_d.sign  = s_data[FIX_W-1];
        s1_d.mag   = MAG_W'(abs_val) << (MAG_W - FIX_W);
    end

    fixed2float_lzc #(
        .WIDTH (MAG_W)
    ) u_lzc (
        .value (s1_q.mag),
        .count (lz),
        .zero  (lz_zero)
    );

    always_comb begin
        s2_d      = s1_q;
        s2_d.exp  = EXP_FW'(lz);
        s2_d.zero = lz_zero;
    end

    // S3: an all-zero magnitude shifts by MAG_W and stays zero.
    always_comb begin
        s3_d     = s2_q;
        s3_d.mag = s2_q.mag << s2_q.exp;
        s3_d.exp = EXP_FW'(E_OFF) - s2_q.exp;
    end

    // S4: mag[MAG_W-1] is the hidden bit, so it is clear only for a zero sample.
    always_comb begin
        lsb      = s3_q.mag[G_POS+1];
        guard    = s3_q.mag[G_POS];
        sticky   = |s3_q.mag[G_POS-1:0];
        round_up = guard && (sticky || lsb);
        man_sum  = {1'b0, s3_q.mag[MAG_W-2 -: MAN_W]} + MS_W'(round_up);
        exp_out  = EXP_W'(s3_q.exp + EXP_FW'(BIAS_F) + EXP_FW'(man_sum[MAN_W]));
        is_zero  = s3_q.zero || !s3_q.mag[MAG_W-1];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
`ifdef FIXED2FLOAT_FLAGS_EN
            m_inexact <= 1'b0;
`endif
        end else if (!stall) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            m_valid   <= s3_q.valid;
            m_data    <= is_zero ? '0 : {s3_q.sign, exp_out, man_sum[MAN_W-1:0]};
`ifdef FIXED2FLOAT_FLAGS_EN
            m_inexact <= !is_zero && (guard || sticky);
`endif
        end
    end

endmodule
